// File: rtl/rom_ctrl_pkg.sv
// Shared types and constants for the program-ROM fetch path.
package rom_ctrl_pkg;

   // Transaction sequencing of the fetch arbiter.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam int ROM_ADDR_W = 11;
   localparam int ROM_DEPTH  = 2048;
   localparam int MAX_BYTES  = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the port preferred on a tie
// and moves to the other port whenever a grant is taken (grant == accept).
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   logic ptr_q;

   // One-hot grant: a lone requester always wins, a tie goes to the pointer.
   always_comb begin
      gnt_o = 2'b00;
      if (en_i) begin
         case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
         endcase
      end
   end

   // Prefer the port that did not win the last accepted grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 1'b0;
      end else if (|gnt_o) begin
         ptr_q <= gnt_o[0];
      end
   end

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Shares the byte-wide synchronous program ROM between instruction fetch
// (port 0) and table load (port 1). One transaction of 1-4 consecutive bytes
// is in flight at a time; bytes are packed little-endian into a 32-bit word.
//
// Handshakes: a request transfers on a cycle where req_valid[p] & req_ready[p];
// the requester holds payload stable until then. A response is presented with
// rsp_valid[p] held and rsp_data stable until rsp_ready[p] on the same port.
module rom_fetch_arbiter
   import rom_ctrl_pkg::*;
#(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8,
   parameter int RSP_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [ADDR_W-1:0] req_addr0,
   input  logic [ADDR_W-1:0] req_addr1,
   input  logic [1:0]        req_len0,
   input  logic [1:0]        req_len1,
   output logic [1:0]        rsp_valid,
   input  logic [1:0]        rsp_ready,
   output logic [RSP_W-1:0]  rsp_data,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [1:0]        dbg_state_o
);

   state_t            state_q;
   logic              port_q;
   logic [1:0]        len_q;
   logic [1:0]        cnt_q;
   logic              rom_en_q;
   logic [ADDR_W-1:0] rom_addr_q;
   logic [RSP_W-1:0]  pack_q;
   logic [1:0]        rsp_valid_q;
   logic [1:0]        gnt;
   logic [1:0]        byte_idx;

   // Grants are only offered while idle and never while reset is asserted.
   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  ((state_q == IDLE) && rst_n),
      .req_i (req_valid),
      .gnt_o (gnt)
   );

   assign req_ready   = gnt;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = pack_q;
   assign rom_en      = rom_en_q;
   assign rom_addr    = rom_addr_q;
   assign dbg_state_o = state_q;

   // rom_data belongs to the address issued one cycle earlier, hence the -1;
   // in DRAIN the last issued byte (len) is the one arriving.
   always_comb begin
      byte_idx = cnt_q - 2'd1;
      if (state_q == DRAIN) byte_idx = len_q;
   end

   // Transaction FSM: grant, stream addresses, collect bytes, hold response.
   // Byte lanes are addressed as {idx,3'b000}, which relies on DATA_W == 8.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         port_q      <= 1'b0;
         len_q       <= 2'd0;
         cnt_q       <= 2'd0;
         rom_en_q    <= 1'b0;
         rom_addr_q  <= '0;
         pack_q      <= '0;
         rsp_valid_q <= 2'b00;
      end else begin
         case (state_q)
            IDLE: begin
               if (|gnt) begin
                  port_q     <= gnt[1];
                  len_q      <= gnt[1] ? req_len1 : req_len0;
                  rom_addr_q <= gnt[1] ? req_addr1 : req_addr0;
                  cnt_q      <= 2'd0;
                  pack_q     <= '0;
                  rom_en_q   <= 1'b1;
                  state_q    <= READ;
               end
            end
            READ: begin
               if (cnt_q != 2'd0) begin
                  pack_q[{byte_idx, 3'b000} +: DATA_W] <= rom_data;
               end
               if (cnt_q == len_q) begin
                  rom_en_q <= 1'b0;
                  state_q  <= DRAIN;
               end else begin
                  cnt_q      <= cnt_q + 2'd1;
                  rom_addr_q <= rom_addr_q + ADDR_W'(1);
               end
            end
            DRAIN: begin
               pack_q[{byte_idx, 3'b000} +: DATA_W] <= rom_data;
               rsp_valid_q <= port_q ? 2'b10 : 2'b01;
               state_q     <= RESP;
            end
            RESP: begin
               if (rsp_ready[port_q]) begin
                  rsp_valid_q <= 2'b00;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Directed bench for rom_fetch_arbiter with a 1-cycle-latency ROM model.
module tb_rom_fetch_arbiter;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [10:0] req_addr0;
   logic [10:0] req_addr1;
   logic [1:0]  req_len0;
   logic [1:0]  req_len1;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [31:0] rsp_data;
   logic        rom_en;
   logic [10:0] rom_addr;
   logic [7:0]  rom_data;
   logic [1:0]  dbg_state;

   int n_tests;
   int n_fail;
   logic [31:0] exp_q[$];

   rom_fetch_arbiter #(.ADDR_W(11), .DATA_W(8), .RSP_W(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr0   (req_addr0),
      .req_addr1   (req_addr1),
      .req_len0    (req_len0),
      .req_len1    (req_len1),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .rom_en      (rom_en),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .dbg_state_o (dbg_state)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ROM model: mem[i] = i[7:0] ^ 8'h5A, data valid the cycle after rom_en
   initial rom_data = 8'h00;
   always @(posedge clk) begin
      if (rom_en) rom_data <= rom_addr[7:0] ^ 8'h5A;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One complete transaction: request, address stream, response, handshake.
   // Entered and left at posedge+1.
   task automatic txn(input logic [1:0] vld, input logic [1:0] vld_after,
                      input logic exp_port, input logic [10:0] base,
                      input logic [1:0] len, input logic [31:0] exp_data,
                      input int bp_cycles);
      logic [1:0]  onehot;
      logic        seen;
      logic [10:0] a;
      logic [31:0] exp_w;
      onehot = exp_port ? 2'b10 : 2'b01;
      exp_q.push_back(exp_data);
      req_valid = vld;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
         if (req_ready != 2'b00) seen = 1'b1;
      end
      if (!seen) begin
         check("grant_timeout", 32'd0, 32'd1);
         exp_w = exp_q.pop_front();
         req_valid = vld_after;
         return;
      end
      check("grant", 32'(req_ready), 32'(onehot));
      @(posedge clk);
      #1;
      req_valid = vld_after;
      for (int c = 0; c <= int'(len); c++) begin
         @(negedge clk);
         a = base + 11'(c);
         check("rom_en_read", 32'(rom_en), 32'd1);
         check("rom_addr", 32'(rom_addr), 32'(a));
         check("no_grant_busy", 32'(req_ready), 32'd0);
      end
      @(negedge clk);
      check("rom_en_drain", 32'(rom_en), 32'd0);
      check("rsp_early", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      exp_w = exp_q.pop_front();
      check("rsp_valid", 32'(rsp_valid), 32'(onehot));
      check("rsp_data", rsp_data, exp_w);
      rsp_ready = ~onehot;
      for (int i = 0; i < bp_cycles; i++) begin
         @(negedge clk);
         check("bp_valid", 32'(rsp_valid), 32'(onehot));
         check("bp_data", rsp_data, exp_w);
         check("bp_rom_en", 32'(rom_en), 32'd0);
         check("bp_no_grant", 32'(req_ready), 32'd0);
      end
      @(negedge clk);
      rsp_ready = onehot;
      @(posedge clk);
      #1;
      rsp_ready = 2'b00;
      check("rsp_drop", 32'(rsp_valid), 32'd0);
      check("state_idle", 32'(dbg_state), 32'd0);
   endtask

   initial begin
      logic seen;
      logic stray;
      n_tests   = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      req_addr0 = '0;
      req_addr1 = '0;
      req_len0  = '0;
      req_len1  = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_rom_en", 32'(rom_en), 32'd0);
      check("rst_rom_addr", 32'(rom_addr), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // 1) P0 single byte
      req_addr0 = 11'h010; req_len0 = 2'd0;
      txn(2'b01, 2'b00, 1'b0, 11'h010, 2'd0, 32'h0000004A, 0);

      // 2) P1 four bytes
      req_addr1 = 11'h100; req_len1 = 2'd3;
      txn(2'b10, 2'b00, 1'b1, 11'h100, 2'd3, 32'h59585B5A, 0);

      // 4) Contention: both valid throughout, grants alternate 0,1,0,1
      req_addr0 = 11'h020; req_len0 = 2'd0;
      req_addr1 = 11'h030; req_len1 = 2'd0;
      txn(2'b11, 2'b11, 1'b0, 11'h020, 2'd0, 32'h0000007A, 0);
      txn(2'b11, 2'b11, 1'b1, 11'h030, 2'd0, 32'h0000006A, 0);
      txn(2'b11, 2'b11, 1'b0, 11'h020, 2'd0, 32'h0000007A, 0);
      txn(2'b11, 2'b00, 1'b1, 11'h030, 2'd0, 32'h0000006A, 0);

      // 3) Address wrap on port 0
      req_addr0 = 11'h7FE; req_len0 = 2'd3;
      txn(2'b01, 2'b00, 1'b0, 11'h7FE, 2'd3, 32'h5B5AA5A4, 0);

      // 5) Backpressure with port 0 waiting; pointer favours port 1
      req_addr0 = 11'h050; req_len0 = 2'd0;
      req_addr1 = 11'h040; req_len1 = 2'd1;
      txn(2'b11, 2'b01, 1'b1, 11'h040, 2'd1, 32'h00001B1A, 10);
      txn(2'b01, 2'b00, 1'b0, 11'h050, 2'd0, 32'h0000000A, 0);

      // 6) Reset during the second read cycle of a P1 transaction
      req_addr1 = 11'h200; req_len1 = 2'd3;
      req_valid = 2'b10;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (req_ready[1]) seen = 1'b1;
      end
      check("r6_grant", 32'(seen), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      @(negedge clk);
      check("r6_addr0", 32'(rom_addr), 32'h200);
      @(posedge clk);
      #1;
      check("r6_addr1", 32'(rom_addr), 32'h201);
      #2;
      rst_n = 1'b0;
      req_valid = 2'b11;
      #1;
      check("r6_rom_en", 32'(rom_en), 32'd0);
      check("r6_rom_addr", 32'(rom_addr), 32'd0);
      check("r6_rsp_valid", 32'(rsp_valid), 32'd0);
      check("r6_rsp_data", rsp_data, 32'd0);
      check("r6_req_ready", 32'(req_ready), 32'd0);
      stray = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (rsp_valid != 2'b00 || rom_en || req_ready != 2'b00) stray = 1'b1;
      end
      check("r6_quiet", 32'(stray), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      req_addr0 = 11'h060; req_len0 = 2'd0;
      req_addr1 = 11'h070; req_len1 = 2'd0;
      txn(2'b11, 2'b00, 1'b0, 11'h060, 2'd0, 32'h0000003A, 0);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
